// File: rtl/uart_tx_sequencer.sv
// UART transmitter that pops words from a first-word-fall-through FIFO and frames them.
// Optional CTS flow control is enabled by defining UART_TX_CTS_FLOW_EN.
module uart_tx_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_enable,
  input  logic [DIV_WIDTH-1:0]  i_baud_div,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_two_stop,
  input  logic                  i_fifo_valid,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_req,
  input  logic                  i_cts,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cts_gate;
  logic                  launch;
  logic                  bit_end;

`ifdef UART_TX_CTS_FLOW_EN
  assign cts_gate = i_cts;
`else
  logic unused_cts;
  assign unused_cts = i_cts;
  assign cts_gate   = 1'b1;
`endif

  // Reset gating keeps the combinational pop quiet while reset is held.
  assign launch  = i_nrst && (state_q == S_IDLE) && i_enable && i_fifo_valid && cts_gate;
  assign bit_end = (baud_cnt_q == div_q);

  // State and output registers
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state: frame sequencing and launch-time latching of word and configuration
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop_idx_d = stop_idx_q;
    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_WIDTH'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d    = S_START;
          baud_cnt_d = '0;
          div_d      = i_baud_div;
          bit_cnt_d  = '0;
          shift_d    = i_fifo_data;
          par_en_d   = i_parity_en;
          par_bit_d  = (^i_fifo_data) ^ i_parity_odd;
          two_stop_d = i_two_stop;
          stop_idx_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            stop_idx_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: line level and done pulse are precomputed so they register with the state
  always_comb begin
    tx_d          = 1'b1;
    busy_d        = (state_d != S_IDLE);
    done_d        = 1'b0;
    o_fifo_rd_req = launch;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      S_STOP:   done_d = (baud_cnt_d == div_d) && (stop_idx_d == two_stop_d);
      default:  tx_d = 1'b1;
    endcase
  end

  assign o_tx      = tx_q;
  assign o_busy    = busy_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: directed frames plus randomized traffic
// against a per-clock line model built from the frame rules.
module tb_uart_tx_sequencer;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       pen;
    logic       podd;
    logic       two;
  } frame_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        i_enable = 1'b0;
  logic [15:0] i_baud_div = '0;
  logic        i_parity_en = 1'b0;
  logic        i_parity_odd = 1'b0;
  logic        i_two_stop = 1'b0;
  logic        i_fifo_valid = 1'b0;
  logic [7:0]  i_fifo_data = '0;
  logic        i_cts = 1'b1;
  logic        o_fifo_rd_req, o_tx, o_busy, o_tx_done;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [7:0]  fifo_q[$];
  frame_t      exp_q[$];
  logic [1:0]  stream[$];
  int          pop_cyc[$];

  uart_tx_sequencer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_enable(i_enable), .i_baud_div(i_baud_div),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .i_two_stop(i_two_stop),
    .i_fifo_valid(i_fifo_valid), .i_fifo_data(i_fifo_data), .o_fifo_rd_req(o_fifo_rd_req),
    .i_cts(i_cts), .o_tx(o_tx), .o_busy(o_busy), .o_tx_done(o_tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expand one frame into per-clock {line, done} expectations.
  function automatic void expand(input frame_t f);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
    if (f.pen) bits.push_back((^f.data) ^ f.podd);
    bits.push_back(1'b1);
    if (f.two) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int k = 0; k <= f.div; k++)
        stream.push_back({bits[b], (b == bits.size() - 1) && (k == f.div)});
  endfunction

  // FIFO model: pop on the launch edge and hand the expected frame to the scoreboard.
  logic   drv_seen;
  frame_t drv_f;
  always begin
    @(negedge clk);
    drv_seen = o_fifo_rd_req;
    if (drv_seen)
      drv_f = '{data: i_fifo_data, div: int'(i_baud_div), pen: i_parity_en,
                podd: i_parity_odd, two: i_two_stop};
    @(posedge clk);
    #1;
    if (drv_seen) begin
      fifo_q.delete(0);
      exp_q.push_back(drv_f);
      pop_cyc.push_back(cyc);
    end
    i_fifo_valid = (fifo_q.size() != 0);
    i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  // Monitor: compare {tx, busy, done, rd_req} every clock against the model.
  logic [3:0] mon_exp;
  logic [1:0] mon_ent;
  logic       mon_gate;
  always @(negedge clk) begin
`ifdef UART_TX_CTS_FLOW_EN
    mon_gate = i_cts;
`else
    mon_gate = 1'b1;
`endif
    if (!nrst) begin
      stream.delete();
      exp_q.delete();
      chk("reset_outputs", {28'd0, o_tx, o_busy, o_tx_done, o_fifo_rd_req}, 32'b1000);
    end else begin
      if (stream.size() == 0 && exp_q.size() != 0) expand(exp_q.pop_front());
      if (stream.size() != 0) begin
        mon_ent = stream.pop_front();
        mon_exp = {mon_ent[1], 1'b1, mon_ent[0], 1'b0};
      end else begin
        mon_exp = {1'b1, 1'b0, 1'b0, i_enable & i_fifo_valid & mon_gate};
      end
      chk("line_state", {28'd0, o_tx, o_busy, o_tx_done, o_fifo_rd_req}, {28'd0, mon_exp});
    end
  end

  task automatic wait_idle();
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !o_busy && stream.size() == 0 && exp_q.size() == 0) break;
    end
    if (t >= 3000) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  // Launch-to-done latency and pop count for a single queued word.
  task automatic measure(input string nm, input int exp_clk);
    int launch_t, done_t, pops;
    launch_t = -1; done_t = -1; pops = 0;
    for (int t = 0; t < 500 && done_t < 0; t++) begin
      @(negedge clk);
      if (o_fifo_rd_req) begin
        pops++;
        if (launch_t < 0) launch_t = t;
      end
      if (o_tx_done && launch_t >= 0) done_t = t;
    end
    if (done_t < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else chk({nm, "_done_clock"}, 32'(done_t - launch_t), 32'(exp_clk));
    chk({nm, "_pops"}, 32'(pops), 32'd1);
  endtask

  task automatic set_cfg(input int div, input logic pen, input logic podd, input logic two);
    i_baud_div = 16'(div); i_parity_en = pen; i_parity_odd = podd; i_two_stop = two;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #2 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    i_enable = 1'b1;
    i_cts = 1'b1;

    // div=3, 0x55, even parity, one stop: 11 bits of 4 clocks
    set_cfg(3, 1'b1, 1'b0, 1'b0);
    fifo_q.push_back(8'h55);
    measure("frame_55", 44);
    wait_idle();

    // div=0, 0x00, odd parity, two stops: 12 one-clock bits
    set_cfg(0, 1'b1, 1'b1, 1'b1);
    fifo_q.push_back(8'h00);
    measure("frame_00", 12);
    wait_idle();

    // Empty FIFO with enable high: line stays idle
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_fifo_rd_req || !o_tx || o_busy) cnt++;
    end
    chk("empty_fifo_idle", 32'(cnt), 32'd0);

    // Back-to-back: 20 frame clocks, next launch in the following idle clock
    set_cfg(1, 1'b0, 1'b0, 1'b0);
    pop_cyc.delete();
    fifo_q.push_back(8'hA3);
    fifo_q.push_back(8'h3C);
    wait_idle();
    chk("b2b_pop_count", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) chk("b2b_pop_gap", 32'(pop_cyc[1] - pop_cyc[0]), 32'(10 * 2 + 1));

    // CTS low with a word queued
    i_cts = 1'b0;
    set_cfg(2, 1'b1, 1'b0, 1'b0);
    fifo_q.push_back(8'hC5);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_fifo_rd_req) cnt++;
    end
`ifdef UART_TX_CTS_FLOW_EN
    chk("cts_low_launches", 32'(cnt), 32'd0);
`else
    chk("cts_low_launches", 32'(cnt), 32'd1);
`endif
    wait_idle();
    // CTS dropped mid-frame: frame still completes
    @(posedge clk); #1;
    i_cts = 1'b1;
    fifo_q.push_back(8'h96);
    repeat (8) @(posedge clk);
    #1 i_cts = 1'b0;
    i_enable = 1'b0;
    set_cfg(0, 1'b0, 1'b1, 1'b1);
    wait_idle();
    i_cts = 1'b1;
    i_enable = 1'b1;

    // Reset during DATA: frame aborted, next word launches after release
    set_cfg(2, 1'b0, 1'b0, 1'b0);
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'h0F);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (o_fifo_rd_req) break;
    end
    repeat (10) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    chk("async_reset_tx", 32'(o_tx), 32'd1);
    chk("async_reset_busy", 32'(o_busy), 32'd0);
    chk("async_reset_done", 32'(o_tx_done), 32'd0);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    wait_idle();
    chk("post_reset_queue", 32'(fifo_q.size()), 32'd0);

    // Randomized traffic with mid-frame input changes
    repeat (3000) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 9) == 0 && fifo_q.size() < 3) fifo_q.push_back(8'($urandom));
      if ($urandom_range(0, 15) == 0) i_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) i_cts = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0)
        set_cfg(int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    i_enable = 1'b1;
    i_cts = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
